audio_playback_scheduler: RTL and testbench
===========================================

// Module: audio_playback_scheduler
// PURPOSE
//  Per-sample scheduler for the shared sample ROM feeding the codec DAC path. Shares the single ROM read port
//  between looping background music (BGM) and NUM_SFX one-shot sound effects (SFX) by generating address and rden.
//  Advances one address per sample frame; sits between the codec config sequencer (cfg_done) and the ROM/serializer.
// PARAMETERS
//  ADDR_W     18           ROM address width
//  NUM_SFX    4            number of SFX clips; index 0 = highest priority
//  BGM_START  18'd0        first BGM address
//  BGM_END    18'd214198   last BGM address (inclusive)
//  SFX_START  {NUM_SFX*ADDR_W}  packed clip start addresses, clip i at [i*ADDR_W +: ADDR_W]
//  SFX_END    {NUM_SFX*ADDR_W}  packed clip end addresses (inclusive), SFX_END[i] >= SFX_START[i]
// PORTS
//  DAC_LR_CLK  in   1        sample-frame clock; all logic on rising edge
//  reset       in   1        synchronous, active-low
//  cfg_done    in   1        codec configured; level, already in DAC_LR_CLK domain
//  bgm_en      in   1        1 = BGM plays/loops, 0 = BGM paused (position held)
//  sfx_req     in   NUM_SFX  one-cycle request pulses, one bit per clip
//  rom_addr    out  ADDR_W   registered ROM read address
//  rom_rden    out  1        registered ROM read enable
//  src_sfx     out  1        1 = current address belongs to an SFX
//  sfx_id      out  clog2(NUM_SFX)  active SFX index (valid when src_sfx)
//  sfx_done    out  1        one-cycle pulse after last address of an SFX was issued
// BEHAVIOUR
//  Reset (reset==0 at edge): rom_addr=BGM_START, rom_rden=0, src_sfx=0, sfx_id=0, sfx_done=0, saved BGM pos=BGM_START,
//   pending cleared, state WAIT_CFG.
//  States: WAIT_CFG -> BGM when cfg_done==1; BGM <-> SFX; any state -> WAIT_CFG when cfg_done==0 (same reset values).
//  BGM: bgm_en=1 -> rom_rden=1, rom_addr+1 each edge; at BGM_END next addr = BGM_START (loop).
//   bgm_en=0 -> rom_rden=0, rom_addr held.
//  Request select: highest-priority set bit of (sfx_req | pending), lowest index wins.
//  BGM + any request at edge N: save BGM next address (current+1, wrap applied; current if bgm_en=0);
//   after edge N rom_addr=SFX_START[i], rom_rden=1, src_sfx=1, sfx_id=i. Latency: 0 frames after sampling edge.
//  SFX: rom_addr+1 each edge, rom_rden=1 regardless of bgm_en.
//   After issuing SFX_END[i]: sfx_done=1 for one cycle; if pending -> start it next edge (no BGM frame between);
//   else return to BGM at saved address (rom_rden = bgm_en).
//  Request while SFX i active: index j<i preempts immediately (i abandoned, no sfx_done for i, i NOT re-queued);
//   j==i restarts clip i at SFX_START[i]; j>i latched into 1-deep pending (higher priority overwrites lower).
//  Multiple bits in one edge: winner served, highest remaining bit latched as pending.
//  SFX_START==SFX_END: one address issued, sfx_done next edge.
//  No address ever leaves its clip range [start,end]; no arithmetic overflow beyond ADDR_W.
// STRUCTURE
//  Shared include audio_defs.vh: ADDR_W, BGM_START/END, SFX address map, state encodings
//   (WAIT_CFG=2'd0, BGM=2'd1, SFX=2'd2).
//  Sub-module sfx_prio_enc: NUM_SFX-bit request vector -> {valid, index} lowest-index-first, combinational.
//  Top: FSM, saved-BGM register, pending register, address/next-address mux, output registers.
// TESTING
//  Reset, cfg_done=0 for 10 frames -> rom_rden=0, rom_addr=0; cfg_done=1 -> addr 0,1,2... one per frame.
//  Force BGM at 214198, bgm_en=1 -> next addr 0, rom_rden stays 1, src_sfx=0.
//  BGM at addr 100, pulse sfx_req[2] (SFX2 = 5 addrs) -> 5 SFX addrs, src_sfx=1, sfx_id=2; sfx_done pulse; BGM resumes at 101.
//  SFX2 active, pulse sfx_req[0] -> SFX0 starts next frame, no sfx_done for SFX2; after SFX0 ends BGM resumes.
//  SFX1 active, pulse sfx_req[3] then sfx_req[2] -> pending=2; SFX2 follows SFX1 back-to-back, SFX3 never plays.
//  Mid-SFX drop reset or cfg_done one frame -> all outputs at reset values; bgm_en=0 + SFX -> rden=1 only during SFX.

Source files
------------

// File: rtl/audio_playback_scheduler_pkg.sv
// Shared definitions for the audio playback scheduler.
// Holds the ROM address map (BGM loop range and SFX clip ranges), the
// scheduler state encoding and a helper that picks one clip address out of
// a packed clip address table.
package audio_playback_scheduler_pkg;

  localparam int ADDR_W   = 18;
  localparam int NUM_SFX  = 4;
  localparam int SFX_ID_W = $clog2(NUM_SFX);

  localparam logic [ADDR_W-1:0] BGM_START_DEF = 18'd0;
  localparam logic [ADDR_W-1:0] BGM_END_DEF   = 18'd214198;

  // Clip i sits at [i*ADDR_W +: ADDR_W]; clip 0 is the least significant slot.
  localparam logic [NUM_SFX*ADDR_W-1:0] SFX_START_DEF =
    {18'd223000, 18'd222000, 18'd221000, 18'd220000};
  localparam logic [NUM_SFX*ADDR_W-1:0] SFX_END_DEF =
    {18'd223000, 18'd222004, 18'd221003, 18'd220002};

  typedef enum logic [1:0] {
    ST_WAIT_CFG = 2'd0,
    ST_BGM      = 2'd1,
    ST_SFX      = 2'd2
  } sched_state_e;

  // Extract the address of clip idx from a packed clip address table.
  function automatic logic [ADDR_W-1:0] clip_addr(
    input logic [NUM_SFX*ADDR_W-1:0] map,
    input logic [SFX_ID_W-1:0]       idx
  );
    return map[int'(idx)*ADDR_W +: ADDR_W];
  endfunction

endpackage

// File: rtl/audio_playback_scheduler_if.sv
// Control/ROM-side bundle of the audio playback scheduler.
//   cfg_done  codec configured (level)
//   bgm_en    background music play/pause
//   sfx_req   one-cycle request pulse per SFX clip
//   rom_addr  ROM read address
//   rom_rden  ROM read enable
//   src_sfx   current address belongs to an SFX clip
//   sfx_id    active SFX index (valid with src_sfx)
//   sfx_done  one-cycle pulse after the last address of a clip
// master: the requesting side; slave: the scheduler.
interface audio_playback_scheduler_if;
  import audio_playback_scheduler_pkg::*;

  logic                cfg_done;
  logic                bgm_en;
  logic [NUM_SFX-1:0]  sfx_req;
  logic [ADDR_W-1:0]   rom_addr;
  logic                rom_rden;
  logic                src_sfx;
  logic [SFX_ID_W-1:0] sfx_id;
  logic                sfx_done;

  modport master (
    output cfg_done, bgm_en, sfx_req,
    input  rom_addr, rom_rden, src_sfx, sfx_id, sfx_done
  );

  modport slave (
    input  cfg_done, bgm_en, sfx_req,
    output rom_addr, rom_rden, src_sfx, sfx_id, sfx_done
  );

endinterface

// File: rtl/audio_playback_scheduler_sfx_prio_enc.sv
// Lowest-index-first priority encoder for SFX requests.
//   req   in  N  request vector, bit 0 = highest priority
//   valid out 1  any bit set
//   idx   out W  index of the lowest set bit (0 when none)
module sfx_prio_enc #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [W-1:0] idx
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[k]) begin
        valid = 1'b1;
        idx   = W'(k);
      end else begin
        valid = valid;
        idx   = idx;
      end
    end
  end

endmodule

// File: rtl/audio_playback_scheduler.sv
// Per-sample scheduler for the shared sample ROM: one address per sample
// frame, shared between looping background music and one-shot SFX clips.
//   DAC_LR_CLK  sample-frame clock, rising edge
//   reset       synchronous, active-low
//   bus         slave side of audio_playback_scheduler_if
// Dropping cfg_done behaves like reset and parks the scheduler in WAIT_CFG.
module audio_playback_scheduler
  import audio_playback_scheduler_pkg::*;
#(
  parameter logic [ADDR_W-1:0]         BGM_START = BGM_START_DEF,
  parameter logic [ADDR_W-1:0]         BGM_END   = BGM_END_DEF,
  parameter logic [NUM_SFX*ADDR_W-1:0] SFX_START = SFX_START_DEF,
  parameter logic [NUM_SFX*ADDR_W-1:0] SFX_END   = SFX_END_DEF
) (
  input logic                        DAC_LR_CLK,
  input logic                        reset,
  audio_playback_scheduler_if.slave  bus
);

  localparam logic [NUM_SFX-1:0] ONE_HOT0 = {{(NUM_SFX-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0]  ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  sched_state_e        state_r;
  logic [ADDR_W-1:0]   rom_addr_r;
  logic                rom_rden_r;
  logic                src_sfx_r;
  logic [SFX_ID_W-1:0] sfx_id_r;
  logic                sfx_done_r;
  logic [ADDR_W-1:0]   saved_r;
  logic                pend_v_r;
  logic [SFX_ID_W-1:0] pend_idx_r;

  logic [NUM_SFX-1:0]  pend_vec_s;
  logic [NUM_SFX-1:0]  req_vec_s;
  logic [NUM_SFX-1:0]  rem_vec_s;
  logic                win_v_s;
  logic [SFX_ID_W-1:0] win_idx_s;
  logic                rem_v_s;
  logic [SFX_ID_W-1:0] rem_idx_s;
  logic [ADDR_W-1:0]   bgm_next_s;
  logic [ADDR_W-1:0]   win_start_s;
  logic                last_s;

  // The pending clip competes with fresh requests as if it were one of them.
  always_comb begin
    if (pend_v_r) begin
      pend_vec_s = ONE_HOT0 << pend_idx_r;
    end else begin
      pend_vec_s = '0;
    end
  end

  assign req_vec_s = bus.sfx_req | pend_vec_s;

  sfx_prio_enc #(.N(NUM_SFX), .W(SFX_ID_W)) u_win (
    .req   (req_vec_s),
    .valid (win_v_s),
    .idx   (win_idx_s)
  );

  // Whatever loses this frame's arbitration becomes the next pending clip.
  assign rem_vec_s = req_vec_s & ~(ONE_HOT0 << win_idx_s);

  sfx_prio_enc #(.N(NUM_SFX), .W(SFX_ID_W)) u_rem (
    .req   (rem_vec_s),
    .valid (rem_v_s),
    .idx   (rem_idx_s)
  );

  // Next BGM position: advance with loop wrap while playing, hold while paused.
  always_comb begin
    if (!bus.bgm_en) begin
      bgm_next_s = rom_addr_r;
    end else if (rom_addr_r >= BGM_END) begin
      bgm_next_s = BGM_START;
    end else begin
      bgm_next_s = rom_addr_r + ADDR_ONE;
    end
  end

  assign win_start_s = clip_addr(SFX_START, win_idx_s);
  assign last_s      = (rom_addr_r >= clip_addr(SFX_END, sfx_id_r));

  // Scheduler FSM with registered ROM-side outputs.
  always_ff @(posedge DAC_LR_CLK) begin
    if (!reset || !bus.cfg_done) begin
      state_r    <= ST_WAIT_CFG;
      rom_addr_r <= BGM_START;
      rom_rden_r <= 1'b0;
      src_sfx_r  <= 1'b0;
      sfx_id_r   <= '0;
      sfx_done_r <= 1'b0;
      saved_r    <= BGM_START;
      pend_v_r   <= 1'b0;
      pend_idx_r <= '0;
    end else begin
      sfx_done_r <= 1'b0;
      case (state_r)
        ST_WAIT_CFG: begin
          state_r    <= ST_BGM;
          rom_addr_r <= BGM_START;
          rom_rden_r <= bus.bgm_en;
        end
        ST_BGM: begin
          if (win_v_s) begin
            saved_r    <= bgm_next_s;
            state_r    <= ST_SFX;
            rom_addr_r <= win_start_s;
            rom_rden_r <= 1'b1;
            src_sfx_r  <= 1'b1;
            sfx_id_r   <= win_idx_s;
            pend_v_r   <= rem_v_s;
            pend_idx_r <= rem_idx_s;
          end else begin
            rom_addr_r <= bgm_next_s;
            rom_rden_r <= bus.bgm_en;
          end
        end
        ST_SFX: begin
          sfx_done_r <= last_s;
          // Higher/equal priority preempts or restarts; at clip end anything waiting starts.
          if (win_v_s && ((win_idx_s <= sfx_id_r) || last_s)) begin
            rom_addr_r <= win_start_s;
            rom_rden_r <= 1'b1;
            src_sfx_r  <= 1'b1;
            sfx_id_r   <= win_idx_s;
            pend_v_r   <= rem_v_s;
            pend_idx_r <= rem_idx_s;
          end else if (last_s) begin
            state_r    <= ST_BGM;
            rom_addr_r <= saved_r;
            rom_rden_r <= bus.bgm_en;
            src_sfx_r  <= 1'b0;
            sfx_id_r   <= '0;
            pend_v_r   <= 1'b0;
            pend_idx_r <= '0;
          end else begin
            rom_addr_r <= rom_addr_r + ADDR_ONE;
            rom_rden_r <= 1'b1;
            pend_v_r   <= win_v_s;
            pend_idx_r <= win_idx_s;
          end
        end
        default: begin
          state_r    <= ST_WAIT_CFG;
          rom_addr_r <= BGM_START;
          rom_rden_r <= 1'b0;
          src_sfx_r  <= 1'b0;
          sfx_id_r   <= '0;
          saved_r    <= BGM_START;
          pend_v_r   <= 1'b0;
          pend_idx_r <= '0;
        end
      endcase
    end
  end

  assign bus.rom_addr = rom_addr_r;
  assign bus.rom_rden = rom_rden_r;
  assign bus.src_sfx  = src_sfx_r;
  assign bus.sfx_id   = sfx_id_r;
  assign bus.sfx_done = sfx_done_r;

endmodule

// File: tb/tb_audio_playback_scheduler.sv
// Self-checking bench for audio_playback_scheduler.
// Each frame entry carries the inputs to present before an edge and the
// outputs expected just after it; entries are queued per scenario and
// popped one per frame.
module tb_audio_playback_scheduler;

  localparam int S0 = 220000;
  localparam int S1 = 221000;
  localparam int S2 = 222000;
  localparam int S3 = 223000;

  typedef struct packed {
    logic        rst;
    logic        cfg;
    logic        bgm;
    logic [3:0]  req;
    logic [17:0] addr;
    logic        rden;
    logic        src;
    logic [1:0]  id;
    logic        done;
  } frame_t;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  frame_t q[$];

  audio_playback_scheduler_if bus();

  audio_playback_scheduler dut (
    .DAC_LR_CLK (clk),
    .reset      (reset),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  function automatic frame_t fr(input logic rst, input logic cfg, input logic bgm,
                                input logic [3:0] req, input int addr, input logic rden,
                                input logic src, input int id, input logic done);
    frame_t f;
    f.rst = rst; f.cfg = cfg; f.bgm = bgm; f.req = req;
    f.addr = addr[17:0]; f.rden = rden; f.src = src; f.id = id[1:0]; f.done = done;
    return f;
  endfunction

  // Unchecked bring-up: reset, then play BGM until rom_addr shows target.
  task automatic bring_up(input int target);
    reset = 1'b0; bus.cfg_done = 1'b0; bus.bgm_en = 1'b1; bus.sfx_req = 4'b0000;
    @(posedge clk); #1;
    reset = 1'b1; bus.cfg_done = 1'b1;
    repeat (target + 1) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    repeat (2)  q.push_back(fr(1'b0, 1'b0, 1'b1, 4'b0000, 0, 1'b0, 1'b0, 0, 1'b0));
    repeat (10) q.push_back(fr(1'b1, 1'b0, 1'b1, 4'b0000, 0, 1'b0, 1'b0, 0, 1'b0));
    for (int a = 0; a < 5; a++) q.push_back(fr(1'b1, 1'b1, 1'b1, 4'b0000, a, 1'b1, 1'b0, 0, 1'b0));
    while (q.size() > 0) begin
      frame_t e = q.pop_front();
      reset = e.rst; bus.cfg_done = e.cfg; bus.bgm_en = e.bgm; bus.sfx_req = e.req;
      @(posedge clk); #1;
      bus.sfx_req = 4'b0000;
      checks++;
      if ({bus.rom_addr, bus.rom_rden, bus.src_sfx, bus.sfx_id, bus.sfx_done} !==
          {e.addr, e.rden, e.src, e.id, e.done}) begin
        errors++;
        $display("FAIL reset_bringup: got addr=%0d rden=%b src=%b id=%0d done=%b, expected addr=%0d rden=%b src=%b id=%0d done=%b",
                 bus.rom_addr, bus.rom_rden, bus.src_sfx, bus.sfx_id, bus.sfx_done, e.addr, e.rden, e.src, e.id, e.done);
      end
    end
  endtask

  task automatic test_bgm_wrap();
    bring_up(3);
    force dut.rom_addr_r = 18'd214197;
    #1;
    release dut.rom_addr_r;
    q.push_back(fr(1'b1, 1'b1, 1'b1, 4'b0000, 214198, 1'b1, 1'b0, 0, 1'b0));
    q.push_back(fr(1'b1, 1'b1, 1'b1, 4'b0000, 0, 1'b1, 1'b0, 0, 1'b0));
    q.push_back(fr(1'b1, 1'b1, 1'b1, 4'b0000, 1, 1'b1, 1'b0, 0, 1'b0));
    while (q.size() > 0) begin
      frame_t e = q.pop_front();
      reset = e.rst; bus.cfg_done = e.cfg; bus.bgm_en = e.bgm; bus.sfx_req = e.req;
      @(posedge clk); #1;
      bus.sfx_req = 4'b0000;
      checks++;
      if ({bus.rom_addr, bus.rom_rden, bus.src_sfx, bus.sfx_id, bus.sfx_done} !==
          {e.addr, e.rden, e.src, e.id, e.done}) begin
        errors++;
        $display("FAIL bgm_wrap: got addr=%0d rden=%b src=%b id=%0d done=%b, expected addr=%0d rden=%b src=%b id=%0d done=%b",
                 bus.rom_addr, bus.rom_rden, bus.src_sfx, bus.sfx_id, bus.sfx_done, e.addr, e.rden, e.src, e.id, e.done);
      end
    end
  endtask

  task automatic test_sfx_basic();
    bring_up(100);
    q.push_back(fr(1'b1, 1'b1, 1'b1, 4'b0100, S2, 1'b1, 1'b1, 2, 1'b0));
    for (int k = 1; k < 5; k++) q.push_back(fr(1'b1, 1'b1, 1'b1, 4'b0000, S2 + k, 1'b1, 1'b1, 2, 1'b0));
    q.push_back(fr(1'b1, 1'b1, 1'b1, 4'b0000, 101, 1'b1, 1'b0, 0, 1'b1));
    q.push_back(fr(1'b1, 1'b1, 1'b1, 4'b0000, 102, 1'b1, 1'b0, 0, 1'b0));
    while (q.size() > 0) begin
      frame_t e = q.pop_front();
      reset = e.rst; bus.cfg_done = e.cfg; bus.bgm_en = e.bgm; bus.sfx_req = e.req;
      @(posedge clk); #1;
      bus.sfx_req = 4'b0000;
      checks++;
      if ({bus.rom_addr, bus.rom_rden, bus.src_sfx, bus.sfx_id, bus.sfx_done} !==
          {e.addr, e.rden, e.src, e.id, e.done}) begin
        errors++;
        $display("FAIL sfx_basic: got addr=%0d rden=%b src=%b id=%0d done=%b, expected addr=%0d rden=%b src=%b id=%0d done=%b",
                 bus.rom_addr, bus.rom_rden, bus.src_sfx, bus.sfx_id, bus.sfx_done, e.addr, e.rden, e.src, e.id, e.done);
      end
    end
  endtask

  task automatic test_preempt();
    bring_up(10);
    q.push_back(fr(1'b1, 1'b1, 1'b1, 4'b0100, S2, 1'b1, 1'b1, 2, 1'b0));
    q.push_back(fr(1'b1, 1'b1, 1'b1, 4'b0000, S2 + 1, 1'b1, 1'b1, 2, 1'b0));
    q.push_back(fr(1'b1, 1'b1, 1'b1, 4'b0001, S0, 1'b1, 1'b1, 0, 1'b0));
    q.push_back(fr(1'b1, 1'b1, 1'b1, 4'b0000, S0 + 1, 1'b1, 1'b1, 0, 1'b0));
    q.push_back(fr(1'b1, 1'b1, 1'b1, 4'b0000, S0 + 2, 1'b1, 1'b1, 0, 1'b0));
    q.push_back(fr(1'b1, 1'b1, 1'b1, 4'b0000, 11, 1'b1, 1'b0, 0, 1'b1));
    q.push_back(fr(1'b1, 1'b1, 1'b1, 4'b0000, 12, 1'b1, 1'b0, 0, 1'b0));
    while (q.size() > 0) begin
      frame_t e = q.pop_front();
      reset = e.rst; bus.cfg_done = e.cfg; bus.bgm_en = e.bgm; bus.sfx_req = e.req;
      @(posedge clk); #1;
      bus.sfx_req = 4'b0000;
      checks++;
      if ({bus.rom_addr, bus.rom_rden, bus.src_sfx, bus.sfx_id, bus.sfx_done} !==
          {e.addr, e.rden, e.src, e.id, e.done}) begin
        errors++;
        $display("FAIL preempt: got addr=%0d rden=%b src=%b id=%0d done=%b, expected addr=%0d rden=%b src=%b id=%0d done=%b",
                 bus.rom_addr, bus.rom_rden, bus.src_sfx, bus.sfx_id, bus.sfx_done, e.addr, e.rden, e.src, e.id, e.done);
      end
    end
  endtask

  task automatic test_back_to_back();
    bring_up(20);
    q.push_back(fr(1'b1, 1'b1, 1'b1, 4'b0010, S1, 1'b1, 1'b1, 1, 1'b0));
    q.push_back(fr(1'b1, 1'b1, 1'b1, 4'b1000, S1 + 1, 1'b1, 1'b1, 1, 1'b0));
    q.push_back(fr(1'b1, 1'b1, 1'b1, 4'b0100, S1 + 2, 1'b1, 1'b1, 1, 1'b0));
    q.push_back(fr(1'b1, 1'b1, 1'b1, 4'b0000, S1 + 3, 1'b1, 1'b1, 1, 1'b0));
    q.push_back(fr(1'b1, 1'b1, 1'b1, 4'b0000, S2, 1'b1, 1'b1, 2, 1'b1));
    for (int k = 1; k < 5; k++) q.push_back(fr(1'b1, 1'b1, 1'b1, 4'b0000, S2 + k, 1'b1, 1'b1, 2, 1'b0));
    q.push_back(fr(1'b1, 1'b1, 1'b1, 4'b0000, 21, 1'b1, 1'b0, 0, 1'b1));
    q.push_back(fr(1'b1, 1'b1, 1'b1, 4'b0000, 22, 1'b1, 1'b0, 0, 1'b0));
    while (q.size() > 0) begin
      frame_t e = q.pop_front();
      reset = e.rst; bus.cfg_done = e.cfg; bus.bgm_en = e.bgm; bus.sfx_req = e.req;
      @(posedge clk); #1;
      bus.sfx_req = 4'b0000;
      checks++;
      if ({bus.rom_addr, bus.rom_rden, bus.src_sfx, bus.sfx_id, bus.sfx_done} !==
          {e.addr, e.rden, e.src, e.id, e.done}) begin
        errors++;
        $display("FAIL back_to_back: got addr=%0d rden=%b src=%b id=%0d done=%b, expected addr=%0d rden=%b src=%b id=%0d done=%b",
                 bus.rom_addr, bus.rom_rden, bus.src_sfx, bus.sfx_id, bus.sfx_done, e.addr, e.rden, e.src, e.id, e.done);
      end
    end
  endtask

  task automatic test_multi_bits();
    bring_up(30);
    q.push_back(fr(1'b1, 1'b1, 1'b1, 4'b1010, S1, 1'b1, 1'b1, 1, 1'b0));
    for (int k = 1; k < 4; k++) q.push_back(fr(1'b1, 1'b1, 1'b1, 4'b0000, S1 + k, 1'b1, 1'b1, 1, 1'b0));
    q.push_back(fr(1'b1, 1'b1, 1'b1, 4'b0000, S3, 1'b1, 1'b1, 3, 1'b1));
    q.push_back(fr(1'b1, 1'b1, 1'b1, 4'b0000, 31, 1'b1, 1'b0, 0, 1'b1));
    q.push_back(fr(1'b1, 1'b1, 1'b1, 4'b0000, 32, 1'b1, 1'b0, 0, 1'b0));
    while (q.size() > 0) begin
      frame_t e = q.pop_front();
      reset = e.rst; bus.cfg_done = e.cfg; bus.bgm_en = e.bgm; bus.sfx_req = e.req;
      @(posedge clk); #1;
      bus.sfx_req = 4'b0000;
      checks++;
      if ({bus.rom_addr, bus.rom_rden, bus.src_sfx, bus.sfx_id, bus.sfx_done} !==
          {e.addr, e.rden, e.src, e.id, e.done}) begin
        errors++;
        $display("FAIL multi_bits: got addr=%0d rden=%b src=%b id=%0d done=%b, expected addr=%0d rden=%b src=%b id=%0d done=%b",
                 bus.rom_addr, bus.rom_rden, bus.src_sfx, bus.sfx_id, bus.sfx_done, e.addr, e.rden, e.src, e.id, e.done);
      end
    end
  endtask

  task automatic test_drop();
    bring_up(40);
    q.push_back(fr(1'b1, 1'b1, 1'b1, 4'b0001, S0, 1'b1, 1'b1, 0, 1'b0));
    q.push_back(fr(1'b1, 1'b0, 1'b1, 4'b0000, 0, 1'b0, 1'b0, 0, 1'b0));
    q.push_back(fr(1'b1, 1'b1, 1'b1, 4'b0000, 0, 1'b1, 1'b0, 0, 1'b0));
    q.push_back(fr(1'b1, 1'b1, 1'b1, 4'b0000, 1, 1'b1, 1'b0, 0, 1'b0));
    q.push_back(fr(1'b1, 1'b1, 1'b1, 4'b0100, S2, 1'b1, 1'b1, 2, 1'b0));
    q.push_back(fr(1'b0, 1'b1, 1'b1, 4'b0000, 0, 1'b0, 1'b0, 0, 1'b0));
    q.push_back(fr(1'b1, 1'b1, 1'b1, 4'b0000, 0, 1'b1, 1'b0, 0, 1'b0));
    while (q.size() > 0) begin
      frame_t e = q.pop_front();
      reset = e.rst; bus.cfg_done = e.cfg; bus.bgm_en = e.bgm; bus.sfx_req = e.req;
      @(posedge clk); #1;
      bus.sfx_req = 4'b0000;
      checks++;
      if ({bus.rom_addr, bus.rom_rden, bus.src_sfx, bus.sfx_id, bus.sfx_done} !==
          {e.addr, e.rden, e.src, e.id, e.done}) begin
        errors++;
        $display("FAIL drop_mid_sfx: got addr=%0d rden=%b src=%b id=%0d done=%b, expected addr=%0d rden=%b src=%b id=%0d done=%b",
                 bus.rom_addr, bus.rom_rden, bus.src_sfx, bus.sfx_id, bus.sfx_done, e.addr, e.rden, e.src, e.id, e.done);
      end
    end
  endtask

  task automatic test_bgm_paused();
    bring_up(50);
    q.push_back(fr(1'b1, 1'b1, 1'b0, 4'b0000, 50, 1'b0, 1'b0, 0, 1'b0));
    q.push_back(fr(1'b1, 1'b1, 1'b0, 4'b0000, 50, 1'b0, 1'b0, 0, 1'b0));
    q.push_back(fr(1'b1, 1'b1, 1'b0, 4'b1000, S3, 1'b1, 1'b1, 3, 1'b0));
    q.push_back(fr(1'b1, 1'b1, 1'b0, 4'b0000, 50, 1'b0, 1'b0, 0, 1'b1));
    q.push_back(fr(1'b1, 1'b1, 1'b0, 4'b0000, 50, 1'b0, 1'b0, 0, 1'b0));
    q.push_back(fr(1'b1, 1'b1, 1'b1, 4'b0000, 51, 1'b1, 1'b0, 0, 1'b0));
    while (q.size() > 0) begin
      frame_t e = q.pop_front();
      reset = e.rst; bus.cfg_done = e.cfg; bus.bgm_en = e.bgm; bus.sfx_req = e.req;
      @(posedge clk); #1;
      bus.sfx_req = 4'b0000;
      checks++;
      if ({bus.rom_addr, bus.rom_rden, bus.src_sfx, bus.sfx_id, bus.sfx_done} !==
          {e.addr, e.rden, e.src, e.id, e.done}) begin
        errors++;
        $display("FAIL bgm_paused: got addr=%0d rden=%b src=%b id=%0d done=%b, expected addr=%0d rden=%b src=%b id=%0d done=%b",
                 bus.rom_addr, bus.rom_rden, bus.src_sfx, bus.sfx_id, bus.sfx_done, e.addr, e.rden, e.src, e.id, e.done);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    bus.cfg_done = 1'b0;
    bus.bgm_en = 1'b1;
    bus.sfx_req = 4'b0000;
    #2;
    test_reset();
    test_bgm_wrap();
    test_sfx_basic();
    test_preempt();
    test_back_to_back();
    test_multi_bits();
    test_drop();
    test_bgm_paused();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
